// File: rtl/fx_switch_ctrl.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// fx_switch_ctrl
//
// Footswitch / parameter controller for the distortion LPF/clipper stage.
// Debounces the raw pedal buttons, steps the stage gain on gain presses and
// sequences click-free on/off switching of the stage:
//   ramp mix_level down -> flip fx_en -> hold mute while the 9-tap delay line
//   refills -> ramp mix_level back up.
//
// Build option:
//   SOFT_SWITCH_EN  defined   : full ramp / flush sequencing.
//                   undefined : fx_en toggles on the first sample_tick after a
//                               footswitch press; mix_level is fixed at 255.
//
// Parameters:
//   DEBOUNCE_CYCLES  clk cycles a synchronized level must differ before it
//                    is accepted
//   RAMP_STEP        mix_level change per sample_tick while ramping (1..255)
//   FLUSH_SAMPLES    sample ticks held at mute after the enable flip (1..255)
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   sample_tick  one-clk pulse per audio sample
//   fsw_n        raw on/off footswitch, active-low, asynchronous
//   gain_btn_n   raw gain-step button, active-low, asynchronous
//   fx_en        effect enable to the stage
//   fx_gain      3-bit gain select to the stage
//   mix_level    output scaler, 255 = unity, 0 = mute
//   busy         high while a switch sequence is in progress
//   led          status LED, mirrors fx_en
// -----------------------------------------------------------------------------
module fx_switch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RAMP_STEP       = 8,
  parameter int FLUSH_SAMPLES   = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_tick,
  input  logic       fsw_n,
  input  logic       gain_btn_n,
  output logic       fx_en,
  output logic [2:0] fx_gain,
  output logic [7:0] mix_level,
  output logic       busy,
  output logic       led
);

  localparam int DB_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

  // Elaboration-time range checks on the configuration.
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
  if (RAMP_STEP < 1 || RAMP_STEP > 255) begin : g_bad_ramp_step
    $error("RAMP_STEP must be in 1..255");
  end
  if (FLUSH_SAMPLES < 1 || FLUSH_SAMPLES > 255) begin : g_bad_flush
    $error("FLUSH_SAMPLES must be in 1..255");
  end

  // ---------------------------------------------------------------------------
  // Button conditioning: bit 0 = footswitch, bit 1 = gain button.
  // ---------------------------------------------------------------------------
  logic [1:0]      sync1;
  logic [1:0]      sync2;
  logic [1:0]      accepted;
  logic [1:0]      press;
  logic [DB_W-1:0] db_cnt [2];

  logic sw_press;
  logic gain_press;

  assign sw_press   = press[0];
  assign gain_press = press[1];

  // NOTE: every register here, including the two-entry counter array, is
  // reset explicitly; the array is tiny flop storage, not a RAM, so resetting
  // it costs nothing and keeps the debounce state deterministic after rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= 2'b11;
      sync2     <= 2'b11;
      accepted  <= 2'b11;
      press     <= 2'b00;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples the pre-edge value of its neighbours (sync2 gets the old
      // sync1, not the one written on this line).
      sync1 <= {gain_btn_n, fsw_n};
      sync2 <= sync1;
      press <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != accepted[i]) begin
          if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            accepted[i] <= sync2[i];
            db_cnt[i]   <= '0;
            // Only an accepted 1->0 (press) produces an event.
            press[i]    <= ~sync2[i];
          end else begin
            db_cnt[i] <= db_cnt[i] + DB_W'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Gain path: one pending step, applied on the next sample tick.
  // A press arriving on the tick that consumes the flag re-arms it, so no
  // press is lost; presses while the flag is already set are absorbed.
  // ---------------------------------------------------------------------------
  logic gain_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gain_pend <= 1'b0;
      fx_gain   <= 3'd0;
    end else begin
      if (gain_pend && sample_tick) begin
        fx_gain <= fx_gain + 3'd1;   // wraps 7 -> 0
      end
      gain_pend <= gain_press | (gain_pend & ~sample_tick);
    end
  end

  // ---------------------------------------------------------------------------
  // Switch sequencer
  // ---------------------------------------------------------------------------
  logic sw_pend;
  logic sw_take;
  logic en_d;

`ifdef SOFT_SWITCH_EN

  typedef enum logic [2:0] {
    IDLE,
    RAMP_DOWN,
    SWITCH,
    FLUSH,
    RAMP_UP
  } state_t;

  localparam logic [8:0] STEP9   = 9'(RAMP_STEP);
  localparam logic [7:0] FLUSH_N = 8'(FLUSH_SAMPLES);

  state_t     state;
  state_t     state_d;
  logic [7:0] mix_d;
  logic [7:0] flush_cnt;
  logic [7:0] flush_d;
  logic [7:0] flush_inc;
  logic [8:0] mix_dn;
  logic [8:0] mix_up;
  logic [7:0] dn_sat;
  logic [7:0] up_sat;

  // 9-bit ramp arithmetic: bit 8 flags borrow (down) or overflow (up).
  assign mix_dn    = {1'b0, mix_level} - STEP9;
  assign mix_up    = {1'b0, mix_level} + STEP9;
  assign dn_sat    = mix_dn[8] ? 8'd0   : mix_dn[7:0];
  assign up_sat    = mix_up[8] ? 8'hFF  : mix_up[7:0];
  assign flush_inc = flush_cnt + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      fx_en     <= 1'b0;
      sw_pend   <= 1'b0;
      mix_level <= 8'hFF;
      flush_cnt <= 8'd0;
    end else begin
      state     <= state_d;
      fx_en     <= en_d;
      sw_pend   <= sw_press | (sw_pend & ~sw_take);
      mix_level <= mix_d;
      flush_cnt <= flush_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a hold-value default first, so no
    // path through the case leaves one unassigned and no latch is inferred.
    state_d = state;
    mix_d   = mix_level;
    en_d    = fx_en;
    flush_d = flush_cnt;
    sw_take = 1'b0;
    unique case (state)
      IDLE: begin
        if (sw_pend) begin
          sw_take = 1'b1;
          state_d = RAMP_DOWN;
        end
      end
      RAMP_DOWN: begin
        if (sample_tick) begin
          mix_d = dn_sat;
          if (dn_sat == 8'd0) state_d = SWITCH;
        end
      end
      SWITCH: begin
        en_d    = ~fx_en;
        flush_d = 8'd0;
        state_d = FLUSH;
      end
      FLUSH: begin
        if (sample_tick) begin
          flush_d = flush_inc;
          if (flush_inc == FLUSH_N) state_d = RAMP_UP;
        end
      end
      RAMP_UP: begin
        if (sample_tick) begin
          mix_d = up_sat;
          if (up_sat == 8'hFF) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`else

  typedef enum logic {
    IDLE,
    WAIT_TICK
  } state_t;

  state_t state;
  state_t state_d;

  // Hard switching: no ramps, the scaler stays at unity.
  assign mix_level = 8'hFF;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      fx_en   <= 1'b0;
      sw_pend <= 1'b0;
    end else begin
      state   <= state_d;
      fx_en   <= en_d;
      sw_pend <= sw_press | (sw_pend & ~sw_take);
    end
  end

  always_comb begin
    state_d = state;
    en_d    = fx_en;
    sw_take = 1'b0;
    unique case (state)
      IDLE: begin
        if (sw_pend) begin
          sw_take = 1'b1;
          state_d = WAIT_TICK;
        end
      end
      WAIT_TICK: begin
        // Flip on a sample boundary so the stage never changes mid-sample.
        if (sample_tick) begin
          en_d    = ~fx_en;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`endif

  assign busy = (state != IDLE);
  assign led  = fx_en;

endmodule

// File: tb/tb_fx_switch_ctrl.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// tb_fx_switch_ctrl
//
// Directed bench for fx_switch_ctrl with DEBOUNCE_CYCLES=4, RAMP_STEP=64,
// FLUSH_SAMPLES=9 and a sample_tick every 10 clk. Expected output changes are
// pushed onto per-output queues when a press is driven; a monitor pops and
// compares them whenever the DUT output changes. Works in both builds
// (SOFT_SWITCH_EN defined or not).
// -----------------------------------------------------------------------------
module tb_fx_switch_ctrl;

  localparam int DEB   = 4;
  localparam int STEP  = 64;
  localparam int FLUSH = 9;

  logic       clk;
  logic       rst;
  logic       sample_tick;
  logic       fsw_n;
  logic       gain_btn_n;
  logic       fx_en;
  logic [2:0] fx_gain;
  logic [7:0] mix_level;
  logic       busy;
  logic       led;

  fx_switch_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .RAMP_STEP      (STEP),
    .FLUSH_SAMPLES  (FLUSH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_tick(sample_tick),
    .fsw_n      (fsw_n),
    .gain_btn_n (gain_btn_n),
    .fx_en      (fx_en),
    .fx_gain    (fx_gain),
    .mix_level  (mix_level),
    .busy       (busy),
    .led        (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard queues and counters
  int exp_mix[$];
  int exp_en[$];
  int exp_gain[$];
  int exp_busy[$];
  int n_cmp = 0;
  int n_err = 0;

  // Bench model state
  bit m_en   = 1'b0;
  int m_gain = 0;
  bit mon_en = 1'b0;
  bit tick_en = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, got, exp, $time);
      $error("check %s", tag);
    end
  endtask

  // Advance to 1 ns after the n-th following rising edge.
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // sample_tick changes 2 ns after an edge, so at edge+1 ns it still shows the
  // value the DUT sampled on that edge.
  initial begin
    int phase;
    phase = 0;
    sample_tick = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      phase = (phase == 9) ? 0 : phase + 1;
      sample_tick = tick_en && (phase == 0);
    end
  end

  // Expected output changes for one accepted footswitch press.
  task automatic push_seq();
    int m;
    exp_busy.push_back(1);
`ifdef SOFT_SWITCH_EN
    m = 255;
    while (m > 0) begin
      m = (m > STEP) ? m - STEP : 0;
      exp_mix.push_back(m);
    end
    m_en = ~m_en;
    exp_en.push_back(int'(m_en));
    while (m < 255) begin
      m = (m + STEP > 255) ? 255 : m + STEP;
      exp_mix.push_back(m);
    end
`else
    m = 0;
    m_en = ~m_en;
    exp_en.push_back(int'(m_en));
`endif
    exp_busy.push_back(0);
  endtask

  task automatic clear_queues();
    exp_mix.delete();
    exp_en.delete();
    exp_gain.delete();
    exp_busy.delete();
  endtask

  task automatic press_fsw(input int hold);
    fsw_n = 1'b0;
    cycles(hold);
    fsw_n = 1'b1;
    cycles(8);
  endtask

  task automatic press_gain(input int hold);
    gain_btn_n = 1'b0;
    cycles(hold);
    gain_btn_n = 1'b1;
    cycles(8);
  endtask

  // Wait until every expected change has been observed, bounded.
  task automatic drain(input string tag, input int budget);
    int k;
    k = 0;
    while ((exp_mix.size() + exp_en.size() + exp_gain.size() + exp_busy.size()) != 0
           && k < budget) begin
      cycles(1);
      k++;
    end
    check(tag, exp_mix.size() + exp_en.size() + exp_gain.size() + exp_busy.size(), 0);
  endtask

  task automatic apply_reset();
    mon_en = 1'b0;
    clear_queues();
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    cycles(2);
    m_en   = 1'b0;
    m_gain = 0;
    mon_en = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: compares every output change against the scoreboard.
  // ---------------------------------------------------------------------------
  initial begin
    int  cyc;
    int  zero_cyc;
    int  zero_ticks;
    int  busy_ticks;
    int  e;
    int  prev_mix;
    bit  prev_en;
    int  prev_gain;
    bit  prev_busy;
    logic tk;
    cyc = 0; zero_cyc = -10; zero_ticks = 0; busy_ticks = 0;
    prev_mix = 255; prev_en = 1'b0; prev_gain = 0; prev_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (mon_en) begin
        tk = sample_tick;
        if (prev_mix == 0 && tk) zero_ticks++;
        if (prev_busy && tk) busy_ticks++;

        if (int'(mix_level) != prev_mix) begin
          if (exp_mix.size() == 0) check("mix_unexpected", mix_level, prev_mix);
          else begin
            e = exp_mix.pop_front();
            check("mix_level", mix_level, e);
          end
          check("mix_on_tick", tk, 1);
          if (prev_mix == 0) check("flush_ticks", zero_ticks, FLUSH + 1);
          if (mix_level == 8'd0) begin
            zero_cyc   = cyc;
            zero_ticks = 0;
          end
        end

        if (fx_en != prev_en) begin
          if (exp_en.size() == 0) check("en_unexpected", fx_en, prev_en);
          else begin
            e = exp_en.pop_front();
            check("fx_en", fx_en, e);
          end
          check("led_eq_en", led, fx_en);
`ifdef SOFT_SWITCH_EN
          check("en_1clk_after_mute", cyc, zero_cyc + 1);
`else
          check("en_on_tick", tk, 1);
          check("en_first_tick", busy_ticks, 1);
`endif
        end

        if (int'(fx_gain) != prev_gain) begin
          if (exp_gain.size() == 0) check("gain_unexpected", fx_gain, prev_gain);
          else begin
            e = exp_gain.pop_front();
            check("fx_gain", fx_gain, e);
          end
          check("gain_on_tick", tk, 1);
        end

        if (busy != prev_busy) begin
          if (exp_busy.size() == 0) check("busy_unexpected", busy, prev_busy);
          else begin
            e = exp_busy.pop_front();
            check("busy", busy, e);
          end
          if (busy) busy_ticks = 0;
        end
      end
      prev_mix  = int'(mix_level);
      prev_en   = fx_en;
      prev_gain = int'(fx_gain);
      prev_busy = busy;
    end
  end

  // Absolute bound on run time.
  initial begin
    #500000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int k;
    rst        = 1'b1;
    fsw_n      = 1'b1;
    gain_btn_n = 1'b1;
    cycles(3);

    // Reset state
    check("rst_fx_en", fx_en, 0);
    check("rst_fx_gain", fx_gain, 0);
    check("rst_mix", mix_level, 255);
    check("rst_busy", busy, 0);
    check("rst_led", led, 0);
    rst = 1'b0;
    cycles(2);
    mon_en = 1'b1;

    // Glitch reject: 3 clk low is one short of the debounce window.
    fsw_n = 1'b0;
    cycles(3);
    fsw_n = 1'b1;
    cycles(40);
    check("glitch_busy", busy, 0);
    check("glitch_en", fx_en, 0);
    check("glitch_mix", mix_level, 255);

    // Full switch on
    push_seq();
    press_fsw(20);
    drain("full_switch_drain", 400);
    check("full_switch_en", fx_en, 1);
    cycles(20);

    // Gain wrap: 9 presses -> 1..7, 0, 1
    for (int i = 0; i < 9; i++) begin
      m_gain = (m_gain + 1) % 8;
      exp_gain.push_back(m_gain);
      press_gain(8);
      cycles(25);
    end
    drain("gain_drain", 100);
    check("gain_final", fx_gain, 1);

`ifdef SOFT_SWITCH_EN
    // Queued press: second press during FLUSH starts a new sequence 1 clk
    // after busy falls.
    apply_reset();
    push_seq();
    press_fsw(20);
    k = 0;
    while (!(mix_level == 8'd0 && fx_en == 1'b1) && k < 300) begin
      cycles(1);
      k++;
    end
    check("reach_flush", k < 300, 1);
    push_seq();
    press_fsw(20);
    check("queued_in_flush", mix_level, 0);
    k = 0;
    while (busy && k < 300) begin
      cycles(1);
      k++;
    end
    check("first_seq_done", k < 300, 1);
    cycles(1);
    check("requeue_1clk", busy, 1);
    drain("queued_drain", 400);
    check("queued_final_en", fx_en, 0);
    check("queued_final_mix", mix_level, 255);
    cycles(20);

    // Reset mid-ramp with a press pending; also holds with ticks stopped.
    push_seq();
    press_fsw(20);
    k = 0;
    while (mix_level != 8'd127 && k < 300) begin
      cycles(1);
      k++;
    end
    check("reach_127", k < 300, 1);
    tick_en = 1'b0;
    press_fsw(8);
    cycles(30);
    check("stall_mix", mix_level, 127);
    check("stall_busy", busy, 1);
    tick_en = 1'b1;
    k = 0;
    while (mix_level != 8'd63 && k < 300) begin
      cycles(1);
      k++;
    end
    check("reach_63", k < 300, 1);
    mon_en = 1'b0;
    clear_queues();
    rst = 1'b1;
    #1;
    check("midrst_mix", mix_level, 255);
    check("midrst_busy", busy, 0);
    check("midrst_en", fx_en, 0);
    check("midrst_led", led, 0);
    cycles(2);
    rst    = 1'b0;
    m_en   = 1'b0;
    cycles(1);
    mon_en = 1'b1;
    cycles(300);
    check("midrst_no_pending", busy, 0);
    check("midrst_mix_hold", mix_level, 255);
`else
    // Hard switch back off, then a reset check.
    push_seq();
    press_fsw(20);
    drain("toggle_off_drain", 200);
    check("toggle_off_en", fx_en, 0);
    check("hard_mix", mix_level, 255);
    push_seq();
    press_fsw(20);
    drain("toggle_on_drain", 200);
    check("toggle_on_en", fx_en, 1);
    mon_en = 1'b0;
    clear_queues();
    rst = 1'b1;
    #1;
    check("rst_again_en", fx_en, 0);
    check("rst_again_busy", busy, 0);
    cycles(2);
    rst = 1'b0;
    cycles(20);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
